// File: rtl/cic_decim_ctrl_pkg.sv
// Shared definitions for the CIC decimation chain: default chain geometry
// and the sequencer state encoding used by the controller, comb and integrators.
package cic_pkg;

  localparam int RATE_W_DEF   = 8;  // decimation ratio / phase counter width
  localparam int STAGES_DEF   = 3;  // comb stages = warm-up comb strobes to discard
  localparam int COMB_LAT_DEF = 3;  // clocks from comb_en to registered comb output

  // Sequencer states
  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_WARMUP_ENC = 2'd1;
  localparam logic [1:0] ST_RUN_ENC    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,    // no legal rate loaded
    ST_WARMUP = ST_WARMUP_ENC,  // comb delay lines filling
    ST_RUN    = ST_RUN_ENC      // decimated outputs are valid
  } state_t;

endpackage

// File: rtl/cic_decim_ctrl_if.sv
// Bus between the ADC front end / downstream logic and the decimation sequencer.
//
// Handshake semantics: every control signal here is a single-cycle strobe with
// no back-pressure. cfg_load and in_valid are sampled on the rising edge in the
// cycle they are high; integ_en, comb_en and out_valid are asserted for exactly
// one cycle per event and must be consumed in that cycle. There is no ready.
interface cic_decim_ctrl_if #(
  parameter int RATE_W = cic_pkg::RATE_W_DEF
);
  import cic_pkg::*;

  logic [RATE_W-1:0] cfg_rate;
  logic              cfg_load;
  logic              in_valid;
  logic              integ_en;
  logic              comb_en;
  logic              out_valid;
  logic [RATE_W-1:0] phase;
  logic              running;
  logic              cfg_err;
  state_t            dbg_state;   // sequencer state, for observation only

  // Front end / downstream side
  modport master (
    output cfg_rate, cfg_load, in_valid,
    input  integ_en, comb_en, out_valid, phase, running, cfg_err, dbg_state
  );

  // Sequencer side
  modport slave (
    input  cfg_rate, cfg_load, in_valid,
    output integ_en, comb_en, out_valid, phase, running, cfg_err, dbg_state
  );

endinterface

// File: rtl/cic_decim_ctrl_rate_counter.sv
// Phase counter for the decimation period: holds the latched ratio R, counts
// enabled samples modulo R and flags the sample that closes a period.
module cic_rate_counter #(
  parameter int RATE_W = cic_pkg::RATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,    // latch i_rate as the new ratio
  input  logic              i_clear,   // restart the period at phase 0
  input  logic              i_en,      // one accepted sample
  input  logic [RATE_W-1:0] i_rate,
  output logic [RATE_W-1:0] o_phase,
  output logic              o_wrap     // this sample completes the period
);

  logic [RATE_W-1:0] r_rate;
  logic [RATE_W-1:0] r_phase;
  logic              w_last;

  // With R=0 (reset) R-1 is all ones; the counter is never enabled then.
  assign w_last  = (r_phase == (r_rate - RATE_W'(1)));
  assign o_wrap  = i_en && w_last;
  assign o_phase = r_phase;

  // Ratio latch and modulo-R phase count; clear overrides counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rate  <= '0;
      r_phase <= '0;
    end else begin
      if (i_load) begin
        r_rate <= i_rate;
      end
      if (i_clear) begin
        r_phase <= '0;
      end else if (i_en) begin
        r_phase <= w_last ? '0 : (r_phase + RATE_W'(1));
      end
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimation sequencer: gates integrator clocks per accepted ADC sample,
// issues one comb strobe per R samples, and marks comb outputs valid once the
// first STAGES strobes have filled the comb delay lines.
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int RATE_W   = RATE_W_DEF,
  parameter int STAGES   = STAGES_DEF,
  parameter int COMB_LAT = COMB_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  cic_decim_ctrl_if.slave  bus
);

  localparam int WARM_W = $clog2(STAGES + 1);

  state_t              r_state;
  logic [WARM_W-1:0]   r_warm;
  logic                r_comb_en;
  logic                r_running;
  logic                r_cfg_err;
  logic [COMB_LAT-1:0] r_pipe;

  logic                w_accept;
  logic                w_rate_ok;
  logic                w_wrap;
  logic                w_pipe_in;
  logic [RATE_W-1:0]   w_phase;

  // A load takes priority over a coincident sample, which is dropped.
  assign w_accept  = bus.in_valid && (r_state != ST_IDLE) && !bus.cfg_load;
  assign w_rate_ok = (bus.cfg_rate >= RATE_W'(2));
  // Only strobes issued in RUN follow comb outputs that are fully primed.
  assign w_pipe_in = r_comb_en && (r_state == ST_RUN);

  cic_rate_counter #(
    .RATE_W (RATE_W)
  ) u_rate_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (bus.cfg_load),
    .i_clear (bus.cfg_load),
    .i_en    (w_accept),
    .i_rate  (bus.cfg_rate),
    .o_phase (w_phase),
    .o_wrap  (w_wrap)
  );

  // Sequencer FSM with warm-up strobe count and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_warm    <= '0;
      r_comb_en <= 1'b0;
      r_running <= 1'b0;
      r_cfg_err <= 1'b0;
    end else if (bus.cfg_load) begin
      r_state   <= w_rate_ok ? ST_WARMUP : ST_IDLE;
      r_running <= w_rate_ok;
      r_cfg_err <= !w_rate_ok;
      r_warm    <= '0;
      r_comb_en <= 1'b0;
    end else begin
      r_comb_en <= w_wrap;
      case (r_state)
        ST_WARMUP: begin
          if (r_comb_en) begin
            if (r_warm == WARM_W'(STAGES - 1)) begin
              r_state <= ST_RUN;
              r_warm  <= '0;
            end else begin
              r_warm <= r_warm + WARM_W'(1);
            end
          end
        end
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Valid pipe aligned to the comb output latency; a load flushes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else if (bus.cfg_load) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= (r_pipe << 1) | COMB_LAT'(w_pipe_in);
    end
  end

  assign bus.integ_en  = w_accept;
  assign bus.comb_en   = r_comb_en;
  assign bus.out_valid = r_pipe[COMB_LAT-1];
  assign bus.phase     = w_phase;
  assign bus.running   = r_running;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for the CIC decimation sequencer (STAGES=3, COMB_LAT=3).
module tb_cic_decim_ctrl;
  import cic_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errs;
  logic [15:0] exp_q[$];

  cic_decim_ctrl_if #(.RATE_W(W)) bus ();

  cic_decim_ctrl #(
    .RATE_W   (W),
    .STAGES   (3),
    .COMB_LAT (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [W-1:0] rate, input logic iv);
    bus.cfg_load = ld;
    bus.cfg_rate = rate;
    bus.in_valid = iv;
  endtask

  // One-cycle load pulse; returns at the start of the cycle after the load.
  task automatic load_rate(input logic [W-1:0] rate);
    drive(1'b1, rate, 1'b0);
    step();
    drive(1'b0, rate, 1'b0);
  endtask

  initial begin
    int n_samp;
    int n_comb;
    logic chk_next;
    logic exp_comb;

    n_checks = 0;
    n_errs   = 0;
    rst_n    = 1'b0;
    drive(1'b0, '0, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_integ_en", bus.integ_en, 0);
    check("rst_comb_en", bus.comb_en, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_running", bus.running, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_phase", bus.phase, 0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // 10 sample strobes with no rate loaded: nothing counts
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, (i % 2) == 0);
      #1;
      check("idle_integ_en", bus.integ_en, 0);
      check("idle_comb_en", bus.comb_en, 0);
      check("idle_out_valid", bus.out_valid, 0);
      check("idle_running", bus.running, 0);
      check("idle_phase", bus.phase, 0);
      step();
    end

    // R=4, samples on cycles 1..40: comb at 5,9,..,41; valid from the 4th strobe
    load_rate(8'd4);
    check("r4_running", bus.running, 1);
    check("r4_state", 32'(bus.dbg_state), 32'(ST_WARMUP));
    for (int c = 20; c <= 44; c += 4) exp_q.push_back(16'(c));
    for (int c = 1; c <= 46; c++) begin
      drive(1'b0, 8'd4, c <= 40);
      #1;
      check("r4_integ_en", bus.integ_en, (c <= 40) ? 1 : 0);
      exp_comb = (c >= 5) && (c <= 41) && (((c - 5) % 4) == 0);
      check("r4_comb_en", bus.comb_en, exp_comb);
      check("r4_phase", bus.phase, ((c <= 41) ? (c - 1) : 40) % 4);
      if (c == 13) check("r4_state_warm", 32'(bus.dbg_state), 32'(ST_WARMUP));
      if (c == 14) check("r4_state_run", 32'(bus.dbg_state), 32'(ST_RUN));
      if (bus.out_valid) begin
        if (exp_q.size() > 0) check("r4_ov_cycle", c, exp_q.pop_front());
        else check("r4_ov_extra", bus.out_valid, 0);
      end
      step();
    end
    check("r4_ov_missing", exp_q.size(), 0);

    // Illegal R=1 then legal R=5
    load_rate(8'd1);
    check("r1_cfg_err", bus.cfg_err, 1);
    check("r1_running", bus.running, 0);
    check("r1_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    drive(1'b0, 8'd1, 1'b1);
    #1;
    check("r1_integ_en", bus.integ_en, 0);
    step();
    load_rate(8'd5);
    check("r5_cfg_err", bus.cfg_err, 0);
    check("r5_running", bus.running, 1);
    for (int c = 1; c <= 7; c++) begin
      drive(1'b0, 8'd5, c <= 5);
      #1;
      check("r5_comb_en", bus.comb_en, (c == 6) ? 1 : 0);
      step();
    end

    // Load R=6 colliding with the sample that would close an R=4 period
    load_rate(8'd4);
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 8'd4, 1'b1);
      step();
    end
    check("coll_phase_pre", bus.phase, 3);
    drive(1'b1, 8'd6, 1'b1);
    #1;
    check("coll_integ_en", bus.integ_en, 0);
    step();
    drive(1'b0, 8'd6, 1'b0);
    #1;
    check("coll_comb_en", bus.comb_en, 0);
    check("coll_phase", bus.phase, 0);
    check("coll_state", 32'(bus.dbg_state), 32'(ST_WARMUP));
    step();
    check("coll_comb_en2", bus.comb_en, 0);
    for (int c = 1; c <= 7; c++) begin
      drive(1'b0, 8'd6, c <= 6);
      #1;
      check("r6_comb_en", bus.comb_en, (c == 7) ? 1 : 0);
      step();
    end

    // R=2 reaching RUN, then reset with a valid in flight
    load_rate(8'd2);
    for (int c = 1; c <= 9; c++) begin
      drive(1'b0, 8'd2, 1'b1);
      #1;
      check("r2_comb_en", bus.comb_en, (c >= 3 && (c % 2) == 1) ? 1 : 0);
      step();
    end
    check("r2_state", 32'(bus.dbg_state), 32'(ST_RUN));
    rst_n = 1'b0;
    #1;
    check("arst_integ_en", bus.integ_en, 0);
    check("arst_comb_en", bus.comb_en, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_running", bus.running, 0);
    check("arst_phase", bus.phase, 0);
    check("arst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 8'd2, 1'b1);
      #1;
      check("post_rst_out_valid", bus.out_valid, 0);
      check("post_rst_comb_en", bus.comb_en, 0);
      check("post_rst_integ_en", bus.integ_en, 0);
      check("post_rst_running", bus.running, 0);
      step();
    end

    // R=255, a sample every 3rd cycle, 510 samples: two comb strobes
    load_rate(8'd255);
    n_samp   = 0;
    n_comb   = 0;
    chk_next = 1'b0;
    for (int cyc = 0; cyc < 510 * 3 + 6; cyc++) begin
      drive(1'b0, 8'd255, ((cyc % 3) == 0) && (n_samp < 510));
      #1;
      if (bus.comb_en) n_comb++;
      if (chk_next) begin
        check("r255_comb_at_wrap", bus.comb_en, 1);
        check("r255_phase_wrap", bus.phase, 0);
        chk_next = 1'b0;
      end
      if (bus.in_valid) begin
        n_samp++;
        if (n_samp == 255) begin
          check("r255_phase_254", bus.phase, 254);
          check("r255_no_early_comb", n_comb, 0);
          chk_next = 1'b1;
        end
      end
      step();
    end
    check("r255_comb_count", n_comb, 2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Sequencer for the MSO CIC decimation chain: counts incoming ADC sample strobes, produces the per-sample integrator enable and the once-per-R comb enable, and flags which comb outputs are valid once the comb delay lines are filled. It sits between the ADC capture front end and the integrator/`cic_comb` datapath, and presents a single `out_valid` strobe to the downstream trigger/buffer logic. The decimation ratio is runtime-loadable, and every load restarts the sequence cleanly.

## Interface
- `RATE_W`, default 8: width of the decimation ratio and phase counter.
- `STAGES`, default 3: number of comb stages, which is also the number of warm-up comb strobes to discard.
- `COMB_LAT`, default 3: pipeline latency in clocks from `comb_en` to a registered comb output (`y`); must be at least 1.
- `clk`, in, 1: system clock; everything is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cfg_rate`, in, `RATE_W`: decimation ratio R; legal range is 2 .. 2^`RATE_W`-1.
- `cfg_load`, in, 1: single-cycle pulse that latches `cfg_rate` and restarts the sequence.
- `in_valid`, in, 1: one-cycle strobe marking a new ADC sample `x`.
- `integ_en`, out, 1: integrator clock enable.
- `comb_en`, out, 1: comb clock enable, one pulse per R accepted samples.
- `out_valid`, out, 1: the comb output `y` is a valid decimated sample this cycle.
- `phase`, out, `RATE_W`: accepted-sample count within the current decimation period.
- `running`, out, 1: the state is WARMUP or RUN.
- `cfg_err`, out, 1: sticky flag; the last load carried an illegal ratio.

## Operation
- States:
  - IDLE: reset state; no rate is loaded.
  - WARMUP: comb delay lines are filling.
  - RUN: normal operation.
- `cfg_load` is accepted in any state. It latches R and clears `phase`, the warm-up counter and the valid pipe. Then:
  - if `cfg_rate` is 2 or more: go to WARMUP and clear `cfg_err`.
  - if `cfg_rate` is below 2: go to IDLE and set `cfg_err`.
- Accepted sample: `in_valid` is 1, the state is not IDLE, and `cfg_load` is 0.
- `integ_en` is combinational and equals "accepted sample". No samples are counted in IDLE.
- On an accepted sample:
  - if `phase` is R-1: `phase` becomes 0 and `comb_en` pulses on the next cycle.
  - otherwise: `phase` increments by 1.
- The warm-up counter counts `comb_en` pulses in WARMUP. WARMUP moves to RUN on the cycle of the `STAGES`-th pulse.
- Valid pipe: a shift register of depth `COMB_LAT`. Its input is `comb_en` AND (state is RUN).
  - The first `STAGES` comb strobes after a load never produce `out_valid`.
  - `comb_en` keeps firing during WARMUP; the comb must be clocked for its delay lines to fill.
- Simultaneous events:
  - `cfg_load` with `in_valid`: the load wins, the sample is dropped and `integ_en` is 0.
  - `cfg_load` in the cycle a `comb_en` pulse is due: that pulse is suppressed.
  - `cfg_load` while the valid pipe is non-empty: in-flight valids are flushed, so no stale `out_valid` appears.
- A new R takes effect from `phase` 0. There is no mid-period ratio change.
- `in_valid` on back-to-back cycles is legal. With R=2, `comb_en` then pulses every second cycle.

## Timing
- Reset values:
  - `integ_en`, `comb_en`, `out_valid`, `running`, `cfg_err`: 0.
  - `phase`: 0.
  - State: IDLE.
  - Latched R: 0.
- `integ_en`: 0 cycles of latency (combinational from `in_valid`).
- `comb_en`: 1 cycle after the accepted sample that makes `phase` reach R-1; it is a registered pulse.
- `out_valid`: exactly `COMB_LAT` cycles after the qualifying `comb_en`.
- `running`: asserts 1 cycle after a legal `cfg_load` and deasserts 1 cycle after an illegal one.
- `cfg_err`: registered; it updates 1 cycle after `cfg_load`.
- Reset asserted mid-operation forces all outputs low immediately (asynchronously). After reset the block stays in IDLE until the next `cfg_load`.

## Structure
- Shared package `cic_pkg` holds:
  - the state encoding (IDLE/WARMUP/RUN localparams);
  - `RATE_W`, `STAGES` and `COMB_LAT` defaults, also used by `cic_comb` and the integrator.
- One sub-module, `cic_rate_counter`:
  - inputs: load, clear, enable, R;
  - outputs: `phase` and a wrap pulse.
- The FSM, warm-up counter and valid pipe stay at the top level.

## Test plan
All scenarios use `STAGES`=3 and `COMB_LAT`=3.
- Reset, then 10 `in_valid` pulses with no load: `integ_en`, `comb_en`, `out_valid` and `running` all stay 0, and `phase` stays 0.
- Load R=4, then `in_valid` every cycle for 40 cycles:
  - `comb_en` pulses at cycles 4, 8, 12, … after the first sample;
  - the first 3 pulses give no `out_valid`;
  - `out_valid` first appears 3 cycles after the 4th pulse.
- Load R=1: `cfg_err`=1 and `running`=0. Then load R=5: `cfg_err` clears and `running`=1.
- R=4, `cfg_load` (R=6) in the same cycle as `in_valid` while `phase`=3: no `integ_en`, no `comb_en`, `phase`=0, state WARMUP.
- R=2, RUN, `comb_en` in flight: assert `rst_n`=0 for 1 cycle. All outputs drop immediately and no `out_valid` emerges afterwards.
- R=255 (maximum) with sparse `in_valid` (every 3rd cycle): `phase` wraps 254→0, and exactly one `comb_en` pulse appears per 255 samples.
